// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch/exception encodings, exception sequencer states
// and the priority helper that turns the raw exception pulses into one cause.
package cpu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned BYTE_W = 8;

   localparam logic [XLEN-1:0] VEC_BASE_DEFAULT = 32'd253;

   typedef enum logic [1:0] {
      BR_BEQ = 2'b00,
      BR_BNE = 2'b01,
      BR_BLE = 2'b10,
      BR_BGT = 2'b11
   } branch_type_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_OPCODE   = 2'b01,
      CAUSE_OVERFLOW = 2'b10,
      CAUSE_DIV0     = 2'b11
   } exc_cause_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      LOAD = 2'b11
   } exc_state_e;

   typedef struct packed {
      logic       valid;
      exc_cause_e cause;
   } exc_event_t;

   // Opcode beats overflow beats div0; anything lower in the same cycle is dropped.
   function automatic exc_event_t pick_cause(input logic opc,
                                             input logic ovf,
                                             input logic dz);
      exc_event_t ev;
      ev.valid = opc | ovf | dz;
      if (opc)      ev.cause = CAUSE_OPCODE;
      else if (ovf) ev.cause = CAUSE_OVERFLOW;
      else if (dz)  ev.cause = CAUSE_DIV0;
      else          ev.cause = CAUSE_NONE;
      return ev;
   endfunction

endpackage

// File: rtl/pc_exception_unit_branch_cond_eval.sv
// Branch condition evaluator: decides from the ALU flags whether a conditional
// PC write is taken. Purely combinational.
module branch_cond_eval
   import cpu_pkg::*;
(
   input  logic [1:0] branch_type,
   input  logic       alu_zero,
   input  logic       alu_gt,
   output logic       take_c
);

   always_comb begin
      take_c = 1'b0;
      case (branch_type_e'(branch_type))
         BR_BEQ:  take_c = alu_zero;
         BR_BNE:  take_c = ~alu_zero;
         BR_BLE:  take_c = ~alu_gt;
         BR_BGT:  take_c = alu_gt;
         default: take_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_exception_unit.sv
// PC register stage with EPC and a small exception sequencer that fetches the
// handler byte from memory at VEC_BASE+cause-1 and loads it, zero-extended, into PC.
module pc_exception_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [XLEN-1:0] VEC_BASE   = VEC_BASE_DEFAULT,
   parameter logic [XLEN-1:0] EPC_OFFSET = 32'd4,
   parameter int unsigned     MEM_LAT    = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   next_pc,
   input  logic              pc_write,
   input  logic              pc_write_cond,
   input  logic [1:0]        branch_type,
   input  logic              alu_zero,
   input  logic              alu_gt,
   input  logic              exc_opcode,
   input  logic              exc_overflow,
   input  logic              exc_div0,
   input  logic [BYTE_W-1:0] mem_rdata,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   epc,
   output logic              mem_req,
   output logic [XLEN-1:0]   mem_addr,
   output logic              busy,
   output logic [1:0]        exc_cause
);

   localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

   exc_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   pc_d, epc_d, mem_addr_d;
   logic              mem_req_d;
   logic [1:0]        cause_d;
   logic              take_c;
   logic              pc_load_c;
   exc_event_t        exc_ev;

   branch_cond_eval u_branch_cond_eval (
      .branch_type (branch_type),
      .alu_zero    (alu_zero),
      .alu_gt      (alu_gt),
      .take_c      (take_c)
   );

   assign pc_load_c = pc_write | (pc_write_cond & take_c);
   assign exc_ev    = pick_cause(exc_opcode, exc_overflow, exc_div0);

   // State and data registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pc        <= RESET_PC;
         epc       <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         exc_cause <= CAUSE_NONE;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pc        <= pc_d;
         epc       <= epc_d;
         mem_req   <= mem_req_d;
         mem_addr  <= mem_addr_d;
         exc_cause <= cause_d;
      end
   end

   // Next state; while busy, PC writes and further exceptions are ignored
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_d       = pc;
      epc_d      = epc;
      mem_req_d  = 1'b0;
      mem_addr_d = mem_addr;
      cause_d    = exc_cause;
      busy       = 1'b0;

      case (state_q)
         IDLE: begin
            if (exc_ev.valid) begin
               epc_d      = pc - EPC_OFFSET;
               cause_d    = exc_ev.cause;
               mem_req_d  = 1'b1;
               mem_addr_d = VEC_BASE + XLEN'(exc_ev.cause) - XLEN'(1);
               state_d    = REQ;
            end else if (pc_load_c) begin
               pc_d = next_pc;
            end
         end
         REQ: begin
            busy    = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (cnt_q == '0) state_d = LOAD;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         LOAD: begin
            busy    = 1'b1;
            pc_d    = XLEN'(mem_rdata);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pc_exception_unit.sv
// Bench for pc_exception_unit: two instances (memory latency 1 and 3) share the
// control stimulus; each is compared every cycle against a behavioural model.
module tb_pc_exception_unit;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [31:0]       next_pc;
   logic              pc_write, pc_write_cond, alu_zero, alu_gt;
   logic [1:0]        branch_type;
   logic              exc_opcode, exc_overflow, exc_div0;
   logic [1:0][7:0]   rdata_w;
   logic [1:0][31:0]  pc_w, epc_w, addr_w;
   logic [1:0]        req_w, busy_w;
   logic [1:0][1:0]   cause_w;

   int                n_vec = 0;
   int                n_err = 0;
   bit                chk_en = 1'b0;
   int                lat [2] = '{1, 3};
   logic [7:0]        vec [1:3];

   // behavioural model: seq counts busy cycles since exception entry (0 = idle)
   int                seq [2];
   logic [31:0]       m_pc [2];
   logic [31:0]       m_epc [2];
   logic [1:0]        m_cause [2];

   // memory responder state
   int                rcnt [2];
   logic [31:0]       raddr [2];

   always #5 clk = ~clk;

   pc_exception_unit #(.MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .next_pc(next_pc), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .branch_type(branch_type),
      .alu_zero(alu_zero), .alu_gt(alu_gt), .exc_opcode(exc_opcode),
      .exc_overflow(exc_overflow), .exc_div0(exc_div0), .mem_rdata(rdata_w[0]),
      .pc(pc_w[0]), .epc(epc_w[0]), .mem_req(req_w[0]), .mem_addr(addr_w[0]),
      .busy(busy_w[0]), .exc_cause(cause_w[0])
   );

   pc_exception_unit #(.MEM_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .next_pc(next_pc), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .branch_type(branch_type),
      .alu_zero(alu_zero), .alu_gt(alu_gt), .exc_opcode(exc_opcode),
      .exc_overflow(exc_overflow), .exc_div0(exc_div0), .mem_rdata(rdata_w[1]),
      .pc(pc_w[1]), .epc(epc_w[1]), .mem_req(req_w[1]), .mem_addr(addr_w[1]),
      .busy(busy_w[1]), .exc_cause(cause_w[1])
   );

   task automatic chk(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (dut lat=%0d): got %h, expected %h", nm, lat[k], act, exp);
      end
   endtask

   function automatic bit taken(input logic [1:0] bt, input logic z, input logic g);
      case (bt)
         2'd0:    return z;
         2'd1:    return !z;
         2'd2:    return !g;
         default: return g;
      endcase
   endfunction

   // reference model, advanced on every clock edge or reset assertion
   initial begin
      for (int k = 0; k < 2; k++) begin
         seq[k] = 0; m_pc[k] = 0; m_epc[k] = 0; m_cause[k] = 0;
      end
      forever begin
         @(posedge clk or posedge reset);
         for (int k = 0; k < 2; k++) begin
            if (reset) begin
               seq[k] = 0; m_pc[k] = 32'h0; m_epc[k] = 32'h0; m_cause[k] = 2'd0;
            end else if (seq[k] == 0) begin
               if (exc_opcode || exc_overflow || exc_div0) begin
                  m_cause[k] = exc_opcode ? 2'd1 : (exc_overflow ? 2'd2 : 2'd3);
                  m_epc[k]   = m_pc[k] - 32'd4;
                  seq[k]     = 1;
               end else if (pc_write || (pc_write_cond && taken(branch_type, alu_zero, alu_gt))) begin
                  m_pc[k] = next_pc;
               end
            end else if (seq[k] == lat[k] + 2) begin
               m_pc[k] = {24'h0, vec[int'(m_cause[k])]};
               seq[k]  = 0;
            end else begin
               seq[k]++;
            end
         end
      end
   end

   // memory: data valid MEM_LAT cycles after the request, garbage before that
   initial begin
      rcnt[0] = 0; rcnt[1] = 0; raddr[0] = 0; raddr[1] = 0;
      rdata_w = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (reset) begin
               rcnt[k] = 0;
            end else if (req_w[k]) begin
               rcnt[k]    = lat[k];
               raddr[k]   = addr_w[k];
               rdata_w[k] = 8'($urandom);
            end else if (rcnt[k] > 0) begin
               rcnt[k]--;
               if (rcnt[k] == 0) begin
                  if (int'(raddr[k]) >= 253 && int'(raddr[k]) <= 255)
                     rdata_w[k] = vec[int'(raddr[k]) - 252];
                  else
                     rdata_w[k] = 8'h00;
               end
            end
         end
      end
   end

   // compare process
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
               chk("pc", k, pc_w[k], m_pc[k]);
               chk("epc", k, epc_w[k], m_epc[k]);
               chk("exc_cause", k, 32'(cause_w[k]), 32'(m_cause[k]));
               chk("busy", k, 32'(busy_w[k]), 32'(seq[k] != 0));
               chk("mem_req", k, 32'(req_w[k]), 32'(seq[k] == 1));
               if (seq[k] == 1)
                  chk("mem_addr", k, addr_w[k], 32'd252 + 32'(m_cause[k]));
            end
         end
      end
   end

   task automatic clear_in();
      next_pc = 32'h0; pc_write = 1'b0; pc_write_cond = 1'b0; branch_type = 2'b00;
      alu_zero = 1'b0; alu_gt = 1'b0;
      exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
   endtask

   task automatic idle(input int n);
      clear_in();
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int bcnt;
      clear_in();
      for (int i = 1; i <= 3; i++) vec[i] = 8'($urandom) | 8'h01;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("reset_pc", 0, pc_w[0], 32'h0);
      chk("reset_epc", 0, epc_w[0], 32'h0);
      chk("reset_busy", 0, 32'(busy_w[0]), 32'h0);
      chk("reset_mem_req", 0, 32'(req_w[0]), 32'h0);
      chk("reset_mem_addr", 0, addr_w[0], 32'h0);
      chk("reset_cause", 0, 32'(cause_w[0]), 32'h0);
      chk_en = 1'b1;

      // unconditional load, then untaken bne
      next_pc = 32'h100; pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      chk("pc_write_load", 0, pc_w[0], 32'h100);
      pc_write_cond = 1'b1; branch_type = 2'b01; alu_zero = 1'b1; next_pc = 32'h300;
      @(negedge clk);
      chk("bne_z1_hold", 0, pc_w[0], 32'h100);

      // branch table points
      branch_type = 2'b00; alu_zero = 1'b1; alu_gt = 1'b0; next_pc = 32'h104;
      @(negedge clk);
      chk("beq_z1_load", 0, pc_w[0], 32'h104);
      branch_type = 2'b11; alu_zero = 1'b0; alu_gt = 1'b0; next_pc = 32'h108;
      @(negedge clk);
      chk("bgt_gt0_hold", 0, pc_w[0], 32'h104);
      branch_type = 2'b10; alu_gt = 1'b0; next_pc = 32'h10C;
      @(negedge clk);
      chk("ble_gt0_load", 0, pc_w[0], 32'h10C);
      idle(1);

      // overflow at pc=0x24 with handler byte 0x80
      next_pc = 32'h24; pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0; vec[2] = 8'h80; exc_overflow = 1'b1;
      @(negedge clk);
      exc_overflow = 1'b0;
      chk("ovf_mem_req", 0, 32'(req_w[0]), 32'h1);
      chk("ovf_mem_addr", 0, addr_w[0], 32'd254);
      chk("ovf_epc", 0, epc_w[0], 32'h20);
      chk("ovf_cause", 0, 32'(cause_w[0]), 32'h2);
      @(negedge clk);
      chk("ovf_req_pulse", 0, 32'(req_w[0]), 32'h0);
      chk("ovf_busy2", 0, 32'(busy_w[0]), 32'h1);
      @(negedge clk);
      chk("ovf_busy3", 0, 32'(busy_w[0]), 32'h1);
      chk("ovf_pc_old", 0, pc_w[0], 32'h24);
      @(negedge clk);
      chk("ovf_busy_done", 0, 32'(busy_w[0]), 32'h0);
      chk("ovf_pc_new", 0, pc_w[0], 32'h80);
      idle(5);

      // opcode+div0 with pc_write in the same cycle; div0 again while busy
      next_pc = 32'h200; pc_write = 1'b1; exc_opcode = 1'b1; exc_div0 = 1'b1;
      @(negedge clk);
      exc_opcode = 1'b0;
      chk("prio_cause", 0, 32'(cause_w[0]), 32'h1);
      chk("prio_addr", 0, addr_w[0], 32'd253);
      chk("prio_pc_kept", 0, pc_w[0], 32'h80);
      @(negedge clk);
      clear_in();
      chk("busy_pc_kept", 0, pc_w[0], 32'h80);
      repeat (2) @(negedge clk);
      chk("prio_pc_new", 0, pc_w[0], {24'h0, vec[1]});
      chk("prio_cause_hold", 0, 32'(cause_w[0]), 32'h1);
      idle(5);

      // asynchronous reset mid-run
      next_pc = 32'h40; pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      chk("pc_0x40", 0, pc_w[0], 32'h40);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_pc", 0, pc_w[0], 32'h0);
      chk("async_rst_epc", 0, epc_w[0], 32'h0);
      chk("async_rst_busy", 0, 32'(busy_w[0]), 32'h0);
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);

      // div0 at pc=0 on the latency-3 instance
      exc_div0 = 1'b1;
      bcnt = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         exc_div0 = 1'b0;
         if (i == 0) begin
            chk("div0_epc_wrap", 1, epc_w[1], 32'hFFFF_FFFC);
            chk("div0_addr", 1, addr_w[1], 32'd255);
            chk("div0_mem_req", 1, 32'(req_w[1]), 32'h1);
         end
         if (busy_w[1]) bcnt++;
      end
      chk("lat3_busy_cycles", 1, 32'(bcnt), 32'd5);
      chk("lat3_pc_new", 1, pc_w[1], {24'h0, vec[3]});

      // reset while waiting on memory drops the exception
      exc_div0 = 1'b1;
      @(negedge clk);
      exc_div0 = 1'b0;
      @(negedge clk);
      chk("wait_busy", 1, 32'(busy_w[1]), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("wait_rst_busy", 1, 32'(busy_w[1]), 32'h0);
      chk("wait_rst_pc", 1, pc_w[1], 32'h0);
      chk("wait_rst_epc", 1, epc_w[1], 32'h0);
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("wait_rst_lost_pc", 1, pc_w[1], 32'h0);
      chk("wait_rst_lost_busy", 1, 32'(busy_w[1]), 32'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         next_pc       = $urandom;
         pc_write      = ($urandom_range(0, 3) == 0);
         pc_write_cond = ($urandom_range(0, 2) == 0);
         branch_type   = 2'($urandom_range(0, 3));
         alu_zero      = 1'($urandom_range(0, 1));
         alu_gt        = 1'($urandom_range(0, 1));
         exc_opcode    = ($urandom_range(0, 15) == 0);
         exc_overflow  = ($urandom_range(0, 15) == 0);
         exc_div0      = ($urandom_range(0, 15) == 0);
         if (reset) #2 reset = 1'b0;
         else if ($urandom_range(0, 299) == 0) #2 reset = 1'b1;
      end
      @(negedge clk);
      #2 reset = 1'b0;
      idle(10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
